// File: rtl/fastserial_rx_fifo.sv
// Receive elastic buffer: turns rising edges of the fast-serial byte-ready strobe into
// FIFO pushes and re-presents the queued bytes as a show-ahead valid/ready stream.
module fastserial_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_ready,
  output logic [DATA_WIDTH-1:0] o_st_data,
  output logic                  o_st_valid,
  input  logic                  i_st_ready,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [15:0]           o_drop_count,
  input  logic                  i_clear_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic                  r_rdy_q;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_overflow;
  logic [15:0]           r_drop_count;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign w_push  = i_rx_ready & ~r_rdy_q;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
  assign w_pop   = ~w_empty & i_st_ready;
  // When full, a same-cycle pop frees the very slot the push overwrites.
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy_q      <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_rdy_q <= i_rx_ready;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      // A drop in the same cycle as a clear restarts the count at one.
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= i_clear_overflow ? 16'd1 : sat_inc(r_drop_count);
      end else if (i_clear_overflow) begin
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_rx_data;
  end

  assign o_st_data    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign o_st_valid   = ~w_empty;
  assign o_level      = r_wr_ptr - r_rd_ptr;
  assign o_overflow   = r_overflow;
  assign o_drop_count = r_drop_count;

endmodule
